// File: rtl/add_arb_2pl.sv
// add_arb_2pl: two-requester arbiter feeding a shared 2-stage ripple-carry
// adder. Stage 1 adds the low LO bits, stage 2 adds the high bits plus the
// stage-1 carry and registers a result tagged with the winning requester.
// Optional build macro: ARB_FIXED_PRIO_EN selects strict priority for
// requester 0 instead of the default round-robin.
module add_arb_2pl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CNT_W-1:0] ops_done
);

    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

`ifdef ARB_FIXED_PRIO_EN
    // Strict priority: requester 0 always wins, requester 1 may starve.
    always_comb begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
    end
`else
    req_id_e last_gnt_q, last_gnt_d;

    // Round-robin grant: a tie goes to whichever requester did not win last.
    always_comb begin
        gnt0 = req0 & (~req1 | (last_gnt_q == REQ1));
        gnt1 = req1 & (~req0 | (last_gnt_q == REQ0));
    end

    // Remember the winner only on cycles that actually grant.
    always_comb begin
        // NOTE: default first so every path assigns it; no latch is inferred.
        last_gnt_d = last_gnt_q;
        if (gnt1) begin
            last_gnt_d = REQ1;
        end else if (gnt0) begin
            last_gnt_d = REQ0;
        end
    end

    // Last-winner register; reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            last_gnt_q <= REQ1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    logic             grant;
    req_id_e          win;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;
    logic [LO:0]      lo_sum;

    // Operand mux for the winner and the stage-1 low-half add.
    always_comb begin
        grant   = gnt0 | gnt1;
        win     = gnt1 ? REQ1 : REQ0;
        a_sel   = gnt1 ? a1 : a0;
        b_sel   = gnt1 ? b1 : b0;
        cin_sel = gnt1 ? cin1 : cin0;
        lo_sum  = (LO+1)'(a_sel[LO-1:0]) + (LO+1)'(b_sel[LO-1:0]) + (LO+1)'(cin_sel);
    end

    logic          v1_q;
    req_id_e       tag1_q;
    logic [LO-1:0] s_lo_q;
    logic          c_lo_q;
    logic [HI-1:0] a_hi_q;
    logic [HI-1:0] b_hi_q;

    // Stage-1 valid bit; reset drops anything granted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= grant;
        end
    end

    // Stage-1 data, loaded only on a grant.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; v1_q qualifies every use of them.
        if (grant) begin
            tag1_q <= win;
            s_lo_q <= lo_sum[LO-1:0];
            c_lo_q <= lo_sum[LO];
            a_hi_q <= a_sel[WIDTH-1:LO];
            b_hi_q <= b_sel[WIDTH-1:LO];
        end
    end

    logic [HI:0]      hi_sum;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             rsp_valid0_q, rsp_valid0_d;
    logic             rsp_valid1_q, rsp_valid1_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    // Stage-2 high-half add and result/counter next state.
    always_comb begin
        hi_sum       = (HI+1)'(a_hi_q) + (HI+1)'(b_hi_q) + (HI+1)'(c_lo_q);
        sum_d        = sum_q;
        cout_d       = cout_q;
        ops_done_d   = ops_done_q;
        rsp_valid0_d = v1_q & (tag1_q == REQ0);
        rsp_valid1_d = v1_q & (tag1_q == REQ1);
        if (v1_q) begin
            sum_d      = {hi_sum[HI-1:0], s_lo_q};
            cout_d     = hi_sum[HI];
            ops_done_d = ops_done_q + CNT_W'(1);
        end
    end

    // Stage-2 output registers; reset discards in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q        <= '0;
            cout_q       <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign sum        = sum_q;
    assign cout       = cout_q;
    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign ops_done   = ops_done_q;

endmodule
